// File: rtl/arm_pkg.sv
// Shared ARM execute-stage definitions: condition-code encodings and flag bit positions.
package arm_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARMv4 condition evaluator; NV is treated as never-execute.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_t'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: committed flags register, instruction kill gating,
// and the E->M pipeline register.
module cond_unit
  import arm_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic [3:0]      cond_e,
  input  logic [1:0]      flag_w_e,
  input  logic [3:0]      alu_flags,
  input  logic [size-1:0] alu_result_e,
  input  logic [size-1:0] write_data_e,
  input  logic [3:0]      wa3_e,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic            mem_to_reg_e,
  input  logic            pc_src_e,
  output logic            cond_ex_e,
  output logic            pc_src_taken_e,
  output logic [3:0]      flags,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic            mem_to_reg_m,
  output logic            pc_src_m,
  output logic [size-1:0] alu_result_m,
  output logic [size-1:0] write_data_m,
  output logic [3:0]      wa3_m
);

  logic            kill;
  logic [3:0]      flags_d, flags_q;
  logic [3:0]      ctrl_d, ctrl_q;
  logic [size-1:0] alu_result_d, alu_result_q;
  logic [size-1:0] write_data_d, write_data_q;
  logic [3:0]      wa3_d, wa3_q;

  // Evaluated against committed flags so a producer's flags are visible one cycle later.
  cond_check u_cond_check (
    .cond  (cond_e),
    .flags (flags_q),
    .pass  (cond_ex_e)
  );

  assign kill           = flush_e | !cond_ex_e;
  assign pc_src_taken_e = pc_src_e & !kill;

  always_comb begin
    flags_d      = flags_q;
    ctrl_d       = ctrl_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    wa3_d        = wa3_q;
    if (!stall_e) begin
      if (flag_w_e[1] && !kill) begin
        flags_d[FLAG_N] = alu_flags[FLAG_N];
        flags_d[FLAG_Z] = alu_flags[FLAG_Z];
      end
      if (flag_w_e[0] && !kill) begin
        flags_d[FLAG_C] = alu_flags[FLAG_C];
        flags_d[FLAG_V] = alu_flags[FLAG_V];
      end
      ctrl_d       = {reg_write_e, mem_write_e, mem_to_reg_e, pc_src_e} & {4{!kill}};
      alu_result_d = alu_result_e;
      write_data_d = write_data_e;
      wa3_d        = wa3_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q      <= 4'b0000;
      ctrl_q       <= 4'b0000;
      alu_result_q <= '0;
      write_data_q <= '0;
      wa3_q        <= 4'd0;
    end else begin
      flags_q      <= flags_d;
      ctrl_q       <= ctrl_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      wa3_q        <= wa3_d;
    end
  end

  assign flags        = flags_q;
  assign reg_write_m  = ctrl_q[3];
  assign mem_write_m  = ctrl_q[2];
  assign mem_to_reg_m = ctrl_q[1];
  assign pc_src_m     = ctrl_q[0];
  assign alu_result_m = alu_result_q;
  assign write_data_m = write_data_q;
  assign wa3_m        = wa3_q;

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 Parameter: size, default 32, datapath width of result and store-data fields.
REQ-002 Ports: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Ports: reset  in  1  synchronous, active-high reset.
REQ-004 Ports: stall_e  in  1  freeze flags register and E->M register.
REQ-005 Ports: flush_e  in  1  squash the instruction currently in execute.
REQ-006 Ports: cond_e  in  4  ARMv4 condition field of the instruction in execute.
REQ-007 Ports: flag_w_e  in  2  flag write enables; bit1 = N,Z; bit0 = C,V.
REQ-008 Ports: alu_flags  in  4  {N,Z,C,V} from the ALU in the same cycle.
REQ-009 Ports: alu_result_e  in  size  ALU result; write_data_e  in  size  store data; wa3_e  in  4  destination register.
REQ-010 Ports: reg_write_e, mem_write_e, mem_to_reg_e, pc_src_e  in  1 each  unconditioned decoder controls.
REQ-011 Ports: cond_ex_e  out  1  condition passed (combinational).
REQ-012 Ports: pc_src_taken_e  out  1  branch/PC-write taken now (combinational, to fetch).
REQ-013 Ports: flags  out  4  committed {N,Z,C,V}.
REQ-014 Ports: reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m  out  1 each; alu_result_m  out  size; write_data_m  out  size; wa3_m  out  4  registered memory-stage fields.

Function
REQ-015 cond_ex_e SHALL be evaluated from the flags register (not alu_flags): EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 4'b1111 SHALL yield 0.
REQ-016 kill = flush_e | !cond_ex_e; pc_src_taken_e SHALL equal pc_src_e & !kill with zero latency.
REQ-017 On an edge with !stall_e: flags[3:2] SHALL load alu_flags[3:2] iff flag_w_e[1] & !kill; flags[1:0] SHALL load alu_flags[1:0] iff flag_w_e[0] & !kill; otherwise unchanged.
REQ-018 On an edge with !stall_e: M register SHALL load alu_result_e, write_data_e, wa3_e, and each control ANDed with !kill (latency 1 cycle).
REQ-019 On an edge with stall_e: flags and the entire M register SHALL hold; flush_e is ignored (stall has priority).
REQ-020 A killed instruction SHALL produce a bubble: all four M controls 0; data fields load normally but are don't-care.
REQ-021 Back-to-back flag producer/consumer: a conditional instruction in cycle t+1 SHALL observe flags written at the edge ending cycle t; no extra bypass.
REQ-022 A failed-condition instruction SHALL NOT update flags even if flag_w_e is set.

Reset
REQ-023 reset high at an edge SHALL clear flags to 4'b0000 and every M output (controls, data, wa3) to 0, overriding stall_e and flush_e.
REQ-024 Reset mid-operation SHALL discard the in-flight instruction; first post-reset instruction evaluates against flags 0000.

Structure
REQ-025 Condition-code enumeration (EQ..AL, NV) and flag bit indices N=3,Z=2,C=1,V=0 SHALL live in the shared package arm_pkg.
REQ-026 The combinational evaluator SHALL be the sub-module cond_check (inputs cond, flags; output pass); cond_unit holds only registers and gating.

Verification
REQ-027 reset; cond_e=AL, flag_w_e=11, alu_flags=0100 -> next cycle flags=0100; cond_e=EQ, reg_write_e=1 -> cond_ex_e=1, reg_write_m=1.
REQ-028 flags=0100; cond_e=NE, pc_src_e=1, mem_write_e=1 -> pc_src_taken_e=0; next cycle mem_write_m=0, pc_src_m=0.
REQ-029 flags=1000 (N=1,V=0); cond_e=GE -> cond_ex_e=0; cond_e=LT, flag_w_e=01, alu_flags=0011 -> flags becomes 1011 (N,Z unchanged).
REQ-030 stall_e=1 and flush_e=1 together for 2 cycles with flag_w_e=11 -> flags and M register unchanged; release stall with flush_e=1 -> M controls 0.
REQ-031 Sweep all 16 cond_e values against all 16 flags values -> cond_ex_e matches REQ-015 table; 1111 always 0.
REQ-032 reset asserted with stall_e=1 and M holding reg_write_m=1, alu_result_m=32'hDEADBEEF -> next cycle all M outputs 0, flags 0000.
